// File: rtl/ir_nec_transmitter.sv
// NEC infrared frame transmitter: lead mark/space, 32 LSB-first data bits or a repeat code,
// stop mark. Drives a carrier-gated LED output and an active-low envelope for loopback.
module ir_nec_transmitter #(
  parameter int UNIT_CYC   = 28125,
  parameter int CARR_HALF  = 658,
  parameter bit CARRIER_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rpt,
  input  logic [15:0] custom,
  input  logic [7:0]  cmd,
  output logic        busy,
  output logic        done,
  output logic        ir_out,
  output logic        ir_env_n
);

  localparam int CW = $clog2(16 * UNIT_CYC);
  localparam int HW = (CARR_HALF > 1) ? $clog2(CARR_HALF) : 1;

  // Terminal counts (duration - 1) for each state length in NEC units.
  localparam logic [CW-1:0] L16    = CW'(16 * UNIT_CYC - 1);
  localparam logic [CW-1:0] L8     = CW'(8 * UNIT_CYC - 1);
  localparam logic [CW-1:0] L4     = CW'(4 * UNIT_CYC - 1);
  localparam logic [CW-1:0] L3     = CW'(3 * UNIT_CYC - 1);
  localparam logic [CW-1:0] L1     = CW'(UNIT_CYC - 1);
  localparam logic [CW-1:0] CNT_1  = CW'(1);
  localparam logic [HW-1:0] CH_END = HW'(CARR_HALF - 1);
  localparam logic [HW-1:0] CH_1   = HW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK
  } state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt, w_limit;
  logic [5:0]      r_bit_idx;
  logic [31:0]     r_data;
  logic            r_rpt;
  logic            r_phase, w_next_phase;
  logic [HW-1:0]   r_ccnt, w_next_ccnt;
  logic            r_busy, r_done, r_ir, r_env_n;
  logic            w_last, w_accept, w_cur_mark, w_next_mark;

  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_cur_mark  = (r_state == S_LEAD_MARK) || (r_state == S_BIT_MARK) || (r_state == S_STOP_MARK);
  assign w_next_mark = (w_next == S_LEAD_MARK) || (w_next == S_BIT_MARK) || (w_next == S_STOP_MARK);
  assign w_last      = (r_cnt == w_limit);

  always_comb begin
    w_limit = L1;
    case (r_state)
      S_LEAD_MARK:  w_limit = L16;
      S_LEAD_SPACE: w_limit = r_rpt ? L4 : L8;
      S_BIT_SPACE:  w_limit = r_data[0] ? L3 : L1;
      default:      w_limit = L1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (start)  w_next = S_LEAD_MARK;
      S_LEAD_MARK:  if (w_last) w_next = S_LEAD_SPACE;
      S_LEAD_SPACE: if (w_last) w_next = r_rpt ? S_STOP_MARK : S_BIT_MARK;
      S_BIT_MARK:   if (w_last) w_next = S_BIT_SPACE;
      S_BIT_SPACE:  if (w_last) w_next = (r_bit_idx == 6'd31) ? S_STOP_MARK : S_BIT_MARK;
      S_STOP_MARK:  if (w_last) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Carrier restarts high on every mark entry; no mark follows another mark directly.
  always_comb begin
    w_next_phase = r_phase;
    w_next_ccnt  = r_ccnt;
    if (w_next_mark && !w_cur_mark) begin
      w_next_phase = 1'b1;
      w_next_ccnt  = '0;
    end else if (w_next_mark) begin
      if (r_ccnt == CH_END) begin
        w_next_phase = ~r_phase;
        w_next_ccnt  = '0;
      end else begin
        w_next_ccnt  = r_ccnt + CH_1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_data    <= '0;
      r_rpt     <= 1'b0;
      r_phase   <= 1'b0;
      r_ccnt    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ir      <= 1'b0;
      r_env_n   <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else if (r_state != S_IDLE) r_cnt <= r_cnt + CNT_1;

      if (w_accept) begin
        r_rpt     <= rpt;
        r_data    <= {~cmd, cmd, custom};
        r_bit_idx <= '0;
      end else if (r_state == S_BIT_SPACE && w_last && r_bit_idx != 6'd31) begin
        r_data    <= {1'b0, r_data[31:1]};
        r_bit_idx <= r_bit_idx + 6'd1;
      end

      r_phase <= w_next_phase;
      r_ccnt  <= w_next_ccnt;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (r_state == S_STOP_MARK) && w_last;
      r_env_n <= ~w_next_mark;
      r_ir    <= w_next_mark & (CARRIER_EN ? w_next_phase : 1'b1);
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign ir_out   = r_ir;
  assign ir_env_n = r_env_n;

endmodule

// File: tb/tb_ir_nec_transmitter.sv
// Bench for ir_nec_transmitter: decodes the envelope run lengths back into NEC frames and
// compares them with frames queued at stimulus time.
module tb_ir_nec_transmitter;

  localparam int UNIT = 4;
  localparam int CH   = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rpt = 1'b0;
  logic [15:0] custom = '0;
  logic [7:0]  cmd = '0;
  logic        busy, done, ir_out, ir_env_n;

  int n_cmp = 0;
  int n_err = 0;

  // {rpt, busy length[15:0], data word}
  logic [48:0] exp_q[$];

  int          cap_len, cap_carr_err, cap_early_done, cap_extra_done, cap_extra_busy;
  logic [31:0] cap_word;
  bit          cap_pat_ok, cap_rpt, cap_timeout;
  logic        cap_done_end;

  ir_nec_transmitter #(.UNIT_CYC(UNIT), .CARR_HALF(CH), .CARRIER_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .rpt(rpt), .custom(custom), .cmd(cmd),
    .busy(busy), .done(done), .ir_out(ir_out), .ir_env_n(ir_env_n)
  );

  always #5 clk = ~clk;

  // Called at a negedge with the DUT idle; returns at the negedge of the first busy cycle.
  task automatic send(input bit r, input logic [15:0] cu, input logic [7:0] cm, input bit push);
    logic [31:0] w;
    int len;
    rpt = r; custom = cu; cmd = cm; start = 1'b1;
    if (push) begin
      w = {~cm, cm, cu};
      len = r ? 21 * UNIT : (89 + 2 * $countones(w)) * UNIT;
      exp_q.push_back({r, 16'(len), w});
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Samples one frame from the current negedge until busy drops, then optionally watches a few idle cycles.
  task automatic capture(input bit post);
    int runs[$];
    int run;
    logic prev_env, prev_ir, exp_ir;
    logic [31:0] w;
    cap_len = 0; cap_carr_err = 0; cap_early_done = 0; cap_extra_done = 0; cap_extra_busy = 0;
    cap_pat_ok = 1'b1; cap_rpt = 1'b0; cap_timeout = 1'b0; w = '0;
    prev_env = 1'b1; prev_ir = 1'b0; run = 0;
    for (int c = 0; c < 3000 && busy === 1'b1; c++) begin
      cap_len++;
      if (c == 0 && ir_env_n !== 1'b0) cap_pat_ok = 1'b0;
      if (ir_env_n === 1'b0) begin
        exp_ir = prev_env ? 1'b1 : ~prev_ir;
        if (ir_out !== exp_ir) cap_carr_err++;
      end else if (ir_out !== 1'b0) cap_carr_err++;
      if (done === 1'b1) cap_early_done++;
      if (c > 0 && ir_env_n !== prev_env) begin
        runs.push_back(run);
        run = 0;
      end
      run++;
      prev_env = ir_env_n; prev_ir = ir_out;
      @(negedge clk);
    end
    if (busy === 1'b1) cap_timeout = 1'b1;
    runs.push_back(run);
    cap_done_end = done;
    if (runs.size() == 3) begin
      cap_rpt = 1'b1;
      if (runs[0] != 16 * UNIT || runs[1] != 4 * UNIT || runs[2] != UNIT) cap_pat_ok = 1'b0;
    end else if (runs.size() == 67) begin
      if (runs[0] != 16 * UNIT || runs[1] != 8 * UNIT || runs[66] != UNIT) cap_pat_ok = 1'b0;
      for (int i = 0; i < 32; i++) begin
        if (runs[2 + 2 * i] != UNIT) cap_pat_ok = 1'b0;
        if (runs[3 + 2 * i] == 3 * UNIT) w[i] = 1'b1;
        else if (runs[3 + 2 * i] != UNIT) cap_pat_ok = 1'b0;
      end
    end else begin
      cap_pat_ok = 1'b0;
    end
    cap_word = w;
    if (post) begin
      repeat (4) begin
        @(negedge clk);
        if (done === 1'b1) cap_extra_done++;
        if (busy === 1'b1) cap_extra_busy++;
      end
    end
  endtask

  // Sends one frame, decodes it and checks it against the queued expectation.
  task automatic run_frame(input string name, input bit r, input logic [15:0] cu, input logic [7:0] cm);
    logic [48:0] e;
    send(r, cu, cm, 1'b1);
    capture(1'b1);
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL %s queue: got empty exp 1 entry", name);
      return;
    end
    e = exp_q.pop_front();
    n_cmp++; if (cap_timeout) begin n_err++; $display("FAIL %s timeout: busy still 1 exp 0", name); end
    n_cmp++; if (cap_len !== int'(e[47:32])) begin n_err++; $display("FAIL %s busy_len: got %0d exp %0d", name, cap_len, e[47:32]); end
    n_cmp++; if (cap_pat_ok !== 1'b1) begin n_err++; $display("FAIL %s env_pattern: got bad exp NEC timing", name); end
    n_cmp++; if (cap_rpt !== e[48]) begin n_err++; $display("FAIL %s kind: got rpt=%0d exp %0d", name, cap_rpt, e[48]); end
    if (!e[48]) begin
      n_cmp++; if (cap_word !== e[31:0]) begin n_err++; $display("FAIL %s word: got %h exp %h", name, cap_word, e[31:0]); end
    end
    n_cmp++; if (cap_carr_err !== 0) begin n_err++; $display("FAIL %s carrier: got %0d bad cycles exp 0", name, cap_carr_err); end
    n_cmp++; if (cap_early_done !== 0 || cap_done_end !== 1'b1) begin
      n_err++; $display("FAIL %s done_end: got %b (early %0d) exp 1", name, cap_done_end, cap_early_done); end
    n_cmp++; if (cap_extra_done !== 0 || cap_extra_busy !== 0) begin
      n_err++; $display("FAIL %s after_done: got done %0d busy %0d exp 0 0", name, cap_extra_done, cap_extra_busy); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, ir_out, ir_env_n} !== 4'b0001) begin
        n_err++; $display("FAIL reset_hold: got %b exp 0001", {busy, done, ir_out, ir_env_n}); end
    end
    reset = 1'b0; start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, ir_out, ir_env_n} !== 4'b0001) begin
        n_err++; $display("FAIL reset_release: got %b exp 0001", {busy, done, ir_out, ir_env_n}); end
    end
  endtask

  task automatic test_data_zero();
    run_frame("data_zero", 1'b0, 16'h0000, 8'h00);
    n_cmp++; if (cap_len !== 420) begin n_err++; $display("FAIL data_zero_420: got %0d exp 420", cap_len); end
  endtask

  task automatic test_repeat();
    run_frame("repeat", 1'b1, 16'(($urandom_range(0, 65535))), 8'($urandom_range(0, 255)));
    n_cmp++; if (cap_len !== 84) begin n_err++; $display("FAIL repeat_84: got %0d exp 84", cap_len); end
  endtask

  task automatic test_known_word();
    run_frame("known", 1'b0, 16'h6B86, 8'h1A);
    n_cmp++; if (cap_word !== 32'hE51A6B86) begin n_err++; $display("FAIL known_word: got %h exp e51a6b86", cap_word); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      run_frame("random", 1'b0, 16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)));
  endtask

  task automatic test_ignore_start();
    logic [48:0] e;
    send(1'b0, 16'h1234, 8'h11, 1'b1);
    fork
      capture(1'b1);
      begin
        repeat (100) @(negedge clk);
        rpt = 1'b1; custom = 16'hFFFF; cmd = 8'h22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    e = exp_q.pop_front();
    n_cmp++; if (cap_word !== e[31:0] || cap_rpt !== 1'b0) begin
      n_err++; $display("FAIL ignore_word: got %h rpt %0d exp %h rpt 0", cap_word, cap_rpt, e[31:0]); end
    n_cmp++; if (cap_len !== int'(e[47:32])) begin n_err++; $display("FAIL ignore_len: got %0d exp %0d", cap_len, e[47:32]); end
    n_cmp++; if (cap_done_end !== 1'b1 || cap_early_done !== 0 || cap_extra_done !== 0) begin
      n_err++; $display("FAIL ignore_done: got end %b early %0d extra %0d exp 1 0 0", cap_done_end, cap_early_done, cap_extra_done); end
    n_cmp++; if (cap_extra_busy !== 0) begin n_err++; $display("FAIL ignore_no_second: got busy %0d cycles exp 0", cap_extra_busy); end
  endtask

  task automatic test_back_to_back();
    logic [48:0] e;
    send(1'b0, 16'hA5C3, 8'h5A, 1'b1);
    capture(1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (cap_done_end !== 1'b1) begin n_err++; $display("FAIL b2b_first_done: got %b exp 1", cap_done_end); end
    n_cmp++; if (cap_word !== e[31:0] || cap_len !== int'(e[47:32])) begin
      n_err++; $display("FAIL b2b_first: got %h/%0d exp %h/%0d", cap_word, cap_len, e[31:0], e[47:32]); end
    // Start lands in the done cycle.
    send(1'b0, 16'h0F0F, 8'hC4, 1'b1);
    capture(1'b1);
    e = exp_q.pop_front();
    n_cmp++; if (cap_word !== e[31:0] || cap_len !== int'(e[47:32]) || cap_pat_ok !== 1'b1) begin
      n_err++; $display("FAIL b2b_second: got %h/%0d ok %0d exp %h/%0d", cap_word, cap_len, cap_pat_ok, e[31:0], e[47:32]); end
    n_cmp++; if (cap_done_end !== 1'b1 || cap_extra_done !== 0) begin
      n_err++; $display("FAIL b2b_second_done: got %b extra %0d exp 1 0", cap_done_end, cap_extra_done); end
  endtask

  task automatic test_reset_mid();
    int bad_done;
    send(1'b0, 16'h0000, 8'h00, 1'b0);
    // Busy cycle 181 sits in the space of bit 10 (mark 176..179, space 180..183).
    repeat (181) @(negedge clk);
    n_cmp++; if ({busy, ir_env_n} !== 2'b11) begin n_err++; $display("FAIL mid_in_space: got %b exp 11", {busy, ir_env_n}); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if ({busy, done, ir_out, ir_env_n} !== 4'b0001) begin
      n_err++; $display("FAIL mid_abort: got %b exp 0001", {busy, done, ir_out, ir_env_n}); end
    bad_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad_done++;
    end
    n_cmp++; if (bad_done !== 0) begin n_err++; $display("FAIL mid_no_done: got %0d bad cycles exp 0", bad_done); end
    run_frame("after_reset", 1'b0, 16'h0000, 8'h00);
  endtask

  initial begin
    test_reset();
    test_data_zero();
    test_repeat();
    test_known_word();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL queue_drain: got %0d left exp 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ir_nec_transmitter.md
IR_NEC_TRANSMITTER -- requirements
Module: ir_nec_transmitter

Interface
REQ-001 Parameter UNIT_CYC, default 28125, SHALL set clocks per NEC unit (562.5 us at 50 MHz).
REQ-002 Parameter CARR_HALF, default 658, SHALL set clocks per carrier half-period (about 38 kHz at 50 MHz).
REQ-003 Parameter CARRIER_EN, default 1, SHALL select modulation: 1 = modulated ir_out; 0 = ir_out equals the unmodulated envelope.
REQ-004 The port list SHALL be as follows:
  - clk  in  1  single clock; all logic on its rising edge.
  - reset  in  1  synchronous, active-high reset.
  - start  in  1  one-cycle frame request.
  - rpt  in  1  sampled with start: 1 = send a repeat code, 0 = send a data frame.
  - custom  in  16  custom/address code.
  - cmd  in  8  key/command code.
  - busy  out  1  transmission in progress.
  - done  out  1  one-cycle completion pulse.
  - ir_out  out  1  active-high LED drive (carrier-gated mark).
  - ir_env_n  out  1  demodulated envelope, active-low mark, idle high; directly compatible with IR_RECEIVER iIRDA for loopback.

Function
REQ-005 start SHALL be accepted only in IDLE.
  - On acceptance, rpt, custom and cmd SHALL be latched.
  - Later input changes SHALL NOT affect the frame in flight.
REQ-006 start while busy SHALL be ignored, not queued.
REQ-007 The state machine SHALL have states IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE and STOP_MARK.
REQ-008 Data frame timing, in units of UNIT_CYC clocks:
  - LEAD_MARK: 16.
  - LEAD_SPACE: 8.
  - 32 bits, each BIT_MARK 1 then BIT_SPACE 1 (bit 0) or 3 (bit 1).
  - STOP_MARK: 1, then IDLE.
REQ-009 Repeat frame timing: LEAD_MARK 16, LEAD_SPACE 4, STOP_MARK 1, then IDLE; no bits are sent.
REQ-010 Data word SHALL be {~cmd, cmd, custom[15:8], custom[7:0]}, sent bit 0 first (LSB first), matching the IR_RECEIVER oDATA layout.
REQ-011 Every state SHALL last exactly its unit count times UNIT_CYC clocks, using a unit-cycle counter and a 6-bit bit index (0..31).
  - Data frame busy length = (89 + 2k) * UNIT_CYC clocks, where k = number of 1 bits in the 32-bit word.
  - Repeat frame busy length = 21 * UNIT_CYC clocks.
REQ-012 Outputs SHALL be registered.
  - The cycle after start is accepted: busy = 1, ir_env_n = 0.
  - ir_env_n SHALL be 0 in all MARK states and 1 otherwise.
REQ-013 Carrier phase SHALL reset to high at entry of every MARK state and toggle every CARR_HALF clocks within the mark.
  - ir_out = envelope-mark AND carrier phase.
  - ir_out SHALL be 0 in spaces and in IDLE.
REQ-014 When STOP_MARK completes:
  - In the next cycle busy = 0, ir_env_n = 1, and done = 1 for exactly one cycle.
  - A start in that done cycle SHALL be accepted, allowing back-to-back frames.
REQ-015 The bit-index counter and unit-cycle counter SHALL NOT wrap.
  - Leave BIT_SPACE after index 31.
  - Reload the unit-cycle counter at every state entry.

Reset
REQ-016 While reset = 1, the block SHALL go to IDLE with busy = 0, done = 0, ir_out = 0, ir_env_n = 1, and all counters and the shift register cleared.
REQ-017 reset SHALL override a simultaneous start.
REQ-018 Reset mid-frame SHALL abort the frame with no done pulse; the next start SHALL produce a complete frame.

Verification (UNIT_CYC=4, CARR_HALF=1 unless stated)
REQ-019 Hold reset 3 cycles -> busy = 0, done = 0, ir_out = 0, ir_env_n = 1 throughout and after release.
REQ-020 start with custom=0x0000, cmd=0x00, rpt=0 -> k = 8, busy high exactly 420 clocks.
  - ir_env_n: low 64, high 32, then 24 × (low 4, high 4), then 8 × (low 4, high 12), then low 4.
  - Single done pulse at the first cycle busy = 0.
REQ-021 start with rpt=1 -> busy 84 clocks; ir_env_n low 64, high 16, low 4; ir_out alternates 1,0,1,0... starting at 1 during marks and is 0 in the space.
REQ-022 Default parameters, ir_env_n looped into IR_RECEIVER, custom=0x6B86, cmd=0x1A -> receiver oDATA = 0xE51A6B86.
REQ-023 start with cmd=0x11, then start again with cmd=0x22 mid-frame -> transmitted word carries 0x11; exactly one done; no second frame.
REQ-024 reset asserted for 1 cycle during the BIT_SPACE of bit 10 -> next cycle busy = 0, ir_env_n = 1, ir_out = 0, no done; a following start yields a full, correct 420-clock frame.
